// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-computing job scheduler and its arbiter.
package sc_pkg;

  localparam int P_W = 9;
  localparam logic [4:0] WIN_MIN = 5'd8;
  localparam logic [4:0] WIN_MAX = 5'd17;

  typedef logic [9:0] result_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RUN,
    RESP
  } state_t;

endpackage

// File: rtl/sc_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, priority flips to the other requester on accept.
module sc_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // Requester that wins a tie; 0 after reset.
  logic prio;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && req[1]) begin
      gnt = prio ? 2'b10 : 2'b01;
    end else if (req[0]) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (accept && (gnt != 2'b00)) begin
      prio <= gnt[0];
    end
  end

endmodule

// File: rtl/sc_job_scheduler.sv
// Accepts jobs from two requesters, issues them to a stochastic engine one at a time,
// guards each run with a window-scaled watchdog and returns the result over a valid/ready port.
module sc_job_scheduler #(
  parameter int P_W         = sc_pkg::P_W,
  parameter int P_TO_MARGIN = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0,
  input  logic           req1,
  input  logic [P_W-1:0] op_a0,
  input  logic [P_W-1:0] op_b0,
  input  logic [P_W-1:0] op_a1,
  input  logic [P_W-1:0] op_b1,
  input  logic           mode0,
  input  logic           mode1,
  input  logic [4:0]     cfg_win,
  output logic           gnt0,
  output logic           gnt1,
  output logic           eng_start,
  output logic [P_W-1:0] eng_a,
  output logic [P_W-1:0] eng_b,
  output logic           eng_mode,
  output logic [4:0]     eng_win,
  input  logic           eng_done,
  input  logic [9:0]     eng_result,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [9:0]     rsp_data,
  output logic           rsp_err
);

  import sc_pkg::*;

  function automatic logic [4:0] clamp_win(input logic [4:0] win);
    if (win < WIN_MIN) return WIN_MIN;
    if (win > WIN_MAX) return WIN_MAX;
    return win;
  endfunction

  state_t      state, state_next;
  logic [17:0] wd;
  logic [17:0] wd_limit;
  logic        wd_expire;
  logic [1:0]  arb_gnt;
  logic        accept;
  result_t     result;

  // rst_n is active-high despite its name; outputs are masked during reset.
  assign accept    = (state == IDLE) && !rst_n && (req0 || req1);
  assign gnt0      = accept && arb_gnt[0];
  assign gnt1      = accept && arb_gnt[1];
  assign eng_start = (state == ISSUE) && !rst_n;
  assign rsp_valid = (state == RESP) && !rst_n;
  assign result    = eng_result;

  // wd counts completed RUN cycles, so expiry fires on the cycle that completes the limit.
  assign wd_limit  = (18'd1 << eng_win) + 18'(P_TO_MARGIN);
  assign wd_expire = (wd == wd_limit - 18'd1);

  sc_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst_n),
    .req    ({req1, req0}),
    .accept (accept),
    .gnt    (arb_gnt)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (req0 || req1) state_next = ISSUE;
      ISSUE: state_next = RUN;
      RUN:   if (eng_done || wd_expire) state_next = RESP;
      RESP:  if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= IDLE;
      wd       <= '0;
      eng_a    <= '0;
      eng_b    <= '0;
      eng_mode <= 1'b0;
      eng_win  <= WIN_MIN;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_next;
      wd    <= (state == RUN) ? wd + 18'd1 : 18'd0;
      if (accept) begin
        eng_a    <= arb_gnt[1] ? op_a1 : op_a0;
        eng_b    <= arb_gnt[1] ? op_b1 : op_b0;
        eng_mode <= arb_gnt[1] ? mode1 : mode0;
        eng_win  <= clamp_win(cfg_win);
        rsp_id   <= arb_gnt[1];
      end
      // A completion in the expiry cycle still counts as success.
      if (state == RUN) begin
        if (eng_done) begin
          rsp_data <= result;
          rsp_err  <= 1'b0;
        end else if (wd_expire) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sc_job_scheduler.sv
// Directed bench for sc_job_scheduler with a behavioural engine and a response scoreboard.
module tb_sc_job_scheduler;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [8:0] op_a0, op_b0, op_a1, op_b1;
  logic       mode0, mode1;
  logic [4:0] cfg_win;
  logic       gnt0, gnt1;
  logic       eng_start;
  logic [8:0] eng_a, eng_b;
  logic       eng_mode;
  logic [4:0] eng_win;
  logic       eng_done;
  logic [9:0] eng_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [9:0] rsp_data;
  logic       rsp_err;

  typedef struct {
    logic       id;
    logic [9:0] data;
    logic       err;
    int         lat;
    logic [8:0] a;
    logic [4:0] win;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         eng_lat = 0;
  logic [9:0] eng_res = '0;
  bit         poke_done = 0;
  int         eng_cnt = 0;

  sc_job_scheduler #(.P_W(9), .P_TO_MARGIN(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .req1       (req1),
    .op_a0      (op_a0),
    .op_b0      (op_b0),
    .op_a1      (op_a1),
    .op_b1      (op_b1),
    .mode0      (mode0),
    .mode1      (mode1),
    .cfg_win    (cfg_win),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .eng_start  (eng_start),
    .eng_a      (eng_a),
    .eng_b      (eng_b),
    .eng_mode   (eng_mode),
    .eng_win    (eng_win),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model: eng_done eng_lat cycles after eng_start; eng_lat 0 never completes.
  initial begin
    eng_done   = 1'b0;
    eng_result = '0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (poke_done) begin
        eng_done   = 1'b1;
        eng_result = 10'h155;
        poke_done  = 0;
      end else if (rst_n) begin
        eng_cnt = 0;
      end else if (eng_start && eng_lat > 0) begin
        eng_cnt = eng_lat;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_done   = 1'b1;
          eng_result = eng_res;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic get_grant(input logic id, input logic [8:0] a, input logic [8:0] b,
                           input logic m, input logic [4:0] win);
    int   n = 0;
    bit   got = 0;
    exp_t e;
    while (!got && n < 1000) begin
      #1;
      if (gnt0 || gnt1) got = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check("grant_seen", 32'(got), 32'd1);
    check("gnt0", 32'(gnt0), 32'(id == 1'b0));
    check("gnt1", 32'(gnt1), 32'(id == 1'b1));
    e.id  = id;
    e.a   = a;
    e.win = win;
    if (eng_lat == 0) begin
      e.data = '0;
      e.err  = 1'b1;
      e.lat  = int'((32'd1 << win) + 32'd17);
    end else begin
      e.data = eng_res;
      e.err  = 1'b0;
      e.lat  = eng_lat + 1;
    end
    sb.push_back(e);
    @(negedge clk);
    if (id) req1 = 1'b0;
    else    req0 = 1'b0;
    check("gnt_one_cycle", 32'(gnt0 | gnt1), 32'd0);
    check("eng_start", 32'(eng_start), 32'd1);
    check("eng_a", 32'(eng_a), 32'(a));
    check("eng_b", 32'(eng_b), 32'(b));
    check("eng_mode", 32'(eng_mode), 32'(m));
    check("eng_win", 32'(eng_win), 32'(win));
  endtask

  task automatic get_resp(input int hold);
    int   n = 0;
    int   gseen = 0;
    bit   got = 0;
    exp_t e;
    while (!got && n < 2000) begin
      @(negedge clk);
      n++;
      if (gnt0 || gnt1 || (n > 1 && eng_start)) gseen++;
      if (rsp_valid) got = 1;
    end
    check("rsp_seen", 32'(got), 32'd1);
    check("no_grant_in_job", 32'(gseen), 32'd0);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("rsp_latency", 32'(n), 32'(e.lat));
      check("rsp_id", 32'(rsp_id), 32'(e.id));
      check("rsp_data", 32'(rsp_data), 32'(e.data));
      check("rsp_err", 32'(rsp_err), 32'(e.err));
      check("eng_a_held", 32'(eng_a), 32'(e.a));
      check("eng_win_held", 32'(eng_win), 32'(e.win));
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_id", 32'(rsp_id), 32'(e.id));
        check("hold_data", 32'(rsp_data), 32'(e.data));
        check("hold_err", 32'(rsp_err), 32'(e.err));
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_dropped", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    op_a0 = '0; op_b0 = '0; op_a1 = '0; op_b1 = '0;
    mode0 = 1'b0; mode1 = 1'b0; cfg_win = 5'd8; rsp_ready = 1'b0;

    // Reset: request held during reset must not be granted.
    req0 = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("rst_gnt0", 32'(gnt0), 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    check("rst_gnt1", 32'(gnt1), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_eng_a", 32'(eng_a), 32'd0);
    check("rst_eng_b", 32'(eng_b), 32'd0);
    check("rst_eng_mode", 32'(eng_mode), 32'd0);
    check("rst_eng_win", 32'(eng_win), 32'd8);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);

    // Basic multiply job, 256-cycle engine, ready held low for 5 cycles.
    op_a0 = 9'h180; op_b0 = 9'h080; mode0 = 1'b0; cfg_win = 5'd8;
    eng_lat = 256; eng_res = 10'h0A5; req0 = 1'b1;
    get_grant(1'b0, 9'h180, 9'h080, 1'b0, 5'd8);
    get_resp(5);

    // Engine never completes: watchdog abort after 272 RUN cycles.
    eng_lat = 0; op_a1 = 9'h1FF; op_b1 = 9'h001; mode1 = 1'b1; cfg_win = 5'd8; req1 = 1'b1;
    get_grant(1'b1, 9'h1FF, 9'h001, 1'b1, 5'd8);
    get_resp(0);

    // Window clamps; a cfg_win change after grant must not reach the running job.
    eng_lat = 3; eng_res = 10'h3FF; op_a0 = 9'h011; op_b0 = 9'h022; cfg_win = 5'd3; req0 = 1'b1;
    get_grant(1'b0, 9'h011, 9'h022, 1'b0, 5'd8);
    cfg_win = 5'd20;
    get_resp(0);
    eng_res = 10'h200; op_a1 = 9'h033; op_b1 = 9'h044; mode1 = 1'b0; req1 = 1'b1;
    get_grant(1'b1, 9'h033, 9'h044, 1'b0, 5'd17);
    get_resp(1);

    // Round-robin with both requesting after reset: order 0, 1, 0.
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    cfg_win = 5'd10; eng_lat = 4; eng_res = 10'h011;
    op_a0 = 9'h0AA; op_b0 = 9'h055; mode0 = 1'b0;
    op_a1 = 9'h123; op_b1 = 9'h0F0; mode1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    get_grant(1'b0, 9'h0AA, 9'h055, 1'b0, 5'd10);
    req0 = 1'b1;
    get_resp(0);
    eng_res = 10'h122;
    get_grant(1'b1, 9'h123, 9'h0F0, 1'b1, 5'd10);
    req1 = 1'b1;
    get_resp(0);
    eng_res = 10'h233;
    get_grant(1'b0, 9'h0AA, 9'h055, 1'b0, 5'd10);
    req1 = 1'b0;
    get_resp(0);

    // Reset mid-RUN: job abandoned, no response, then a fresh req1 is served.
    eng_lat = 50; eng_res = 10'h0C3; op_a1 = 9'h0C0; op_b1 = 9'h00C; mode1 = 1'b0; req1 = 1'b1;
    get_grant(1'b1, 9'h0C0, 9'h00C, 1'b0, 5'd10);
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    check("midrst_start", 32'(eng_start), 32'd0);
    check("midrst_eng_win", 32'(eng_win), 32'd8);
    check("midrst_eng_a", 32'(eng_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid || eng_start || gnt0 || gnt1) cnt++;
    end
    check("midrst_quiet", 32'(cnt), 32'd0);
    eng_lat = 6; eng_res = 10'h066; req1 = 1'b1;
    get_grant(1'b1, 9'h0C0, 9'h00C, 1'b0, 5'd10);
    get_resp(0);

    // Stray eng_done in IDLE is ignored.
    poke_done = 1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid || eng_start) cnt++;
    end
    check("idle_done_ignored", 32'(cnt), 32'd0);
    eng_lat = 2; eng_res = 10'h001; op_a0 = 9'h100; op_b0 = 9'h100; mode0 = 1'b1; cfg_win = 5'd17; req0 = 1'b1;
    get_grant(1'b0, 9'h100, 9'h100, 1'b1, 5'd17);
    get_resp(2);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
